// File: rtl/wbu_queue_if.sv
// Handshake and status bundle between MEM, the writeback queue, ID, IF and trace.
// Latency: none (wires only).
// Backpressure: carries wb_to_mem_ready toward MEM and id_to_wb_ready from ID.
//
// Ports (slave = queue side):
//   mem_to_wb_valid/_bus  in   MEM entry {pc, regData, regAddr, regW}
//   wb_to_mem_ready       out  queue accepts this cycle
//   id_to_wb_ready        in   ID regfile port takes the head entry
//   wb_to_id_valid/_bus   out  head entry {regData, regAddr, regW_eff}
//   wb_to_if_done         out  retire pulse
//   commit_pc             out  PC of the retiring entry
//   instret               out  retired-instruction count
//   wb_count / wb_idle    out  occupancy / empty
interface wbu_queue_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int DEPTH          = 2,
    parameter int CNT_WIDTH      = 64
);
    logic                                         mem_to_wb_valid;
    logic                                         wb_to_mem_ready;
    logic [PC_WIDTH+DATA_WIDTH+REG_ADDR_WIDTH:0]  mem_to_wb_bus;
    logic                                         id_to_wb_ready;
    logic                                         wb_to_id_valid;
    logic [DATA_WIDTH+REG_ADDR_WIDTH:0]           wb_to_id_bus;
    logic                                         wb_to_if_done;
    logic [PC_WIDTH-1:0]                          commit_pc;
    logic [CNT_WIDTH-1:0]                         instret;
    logic [$clog2(DEPTH+1)-1:0]                   wb_count;
    logic                                         wb_idle;

    modport slave (
        input  mem_to_wb_valid, mem_to_wb_bus, id_to_wb_ready,
        output wb_to_mem_ready, wb_to_id_valid, wb_to_id_bus, wb_to_if_done,
               commit_pc, instret, wb_count, wb_idle
    );

    modport master (
        output mem_to_wb_valid, mem_to_wb_bus, id_to_wb_ready,
        input  wb_to_mem_ready, wb_to_id_valid, wb_to_id_bus, wb_to_if_done,
               commit_pc, instret, wb_count, wb_idle
    );
endinterface

// File: rtl/wbu_queue.sv
// In-order writeback queue between MEM and the ID regfile port, with retire trace.
// Latency: entry pushed at edge t is at the head after edge t (no bus flow-through).
// Backpressure: ready = not full or popping this cycle; full queue push+pop same cycle.
//
// Ports:
//   clk      clock, all state on rising edge
//   rst      synchronous active-high reset; wins over push and pop
//   bus_if   wbu_queue_if.slave: MEM push side, ID pop side, retire/status outputs
module wbu_queue #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int DEPTH          = 2,
    parameter int CNT_WIDTH      = 64
) (
    input  logic          clk,
    input  logic          rst,
    wbu_queue_if.slave    bus_if
);
    localparam int ENTRY_W = PC_WIDTH + DATA_WIDTH + REG_ADDR_WIDTH + 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [OCC_W-1:0]     count;
    logic [CNT_WIDTH-1:0] instret_q;
    logic [ENTRY_W-1:0]   head;
    logic                 not_empty;
    logic                 pop;
    logic                 push;

    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];

    // Reset suppresses the retire pulse in its own cycle, so pop is gated too.
    assign pop  = not_empty && bus_if.id_to_wb_ready && !rst;
    assign push = bus_if.mem_to_wb_valid && bus_if.wb_to_mem_ready && !rst;

    assign bus_if.wb_to_mem_ready = (count < OCC_W'(DEPTH)) || pop;
    assign bus_if.wb_to_id_valid  = not_empty;

    // x0 is hardwired zero: keep data/addr for trace but drop the write enable.
    assign bus_if.wb_to_id_bus = {head[DATA_WIDTH+REG_ADDR_WIDTH:1],
                                  head[0] && (head[REG_ADDR_WIDTH:1] != '0)};

    assign bus_if.wb_to_if_done = pop;
    assign bus_if.commit_pc     = head[ENTRY_W-1 -: PC_WIDTH];
    assign bus_if.instret       = instret_q;
    assign bus_if.wb_count      = count;
    assign bus_if.wb_idle       = !not_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            instret_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is deliberately not reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_if.mem_to_wb_bus;
        end
    end
endmodule

// File: tb/tb_wbu_queue.sv
// Bench for wbu_queue: DEPTH=1, DEPTH=2 and DEPTH=4 (4-bit instret) driven with shared stimulus.
// Each instance is compared every cycle against a per-instance log-based reference queue.
module tb_wbu_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        mv;
    logic        idr;
    logic [69:0] mbus;

    always #5 clk = ~clk;

    wbu_queue_if #(.DEPTH(1))                 if1 ();
    wbu_queue_if #(.DEPTH(2))                 if2 ();
    wbu_queue_if #(.DEPTH(4), .CNT_WIDTH(4))  if4 ();

    wbu_queue #(.DEPTH(1))                u_d1 (.clk(clk), .rst(rst), .bus_if(if1));
    wbu_queue #(.DEPTH(2))                u_d2 (.clk(clk), .rst(rst), .bus_if(if2));
    wbu_queue #(.DEPTH(4), .CNT_WIDTH(4)) u_d4 (.clk(clk), .rst(rst), .bus_if(if4));

    assign if1.mem_to_wb_valid = mv;  assign if1.mem_to_wb_bus = mbus;  assign if1.id_to_wb_ready = idr;
    assign if2.mem_to_wb_valid = mv;  assign if2.mem_to_wb_bus = mbus;  assign if2.id_to_wb_ready = idr;
    assign if4.mem_to_wb_valid = mv;  assign if4.mem_to_wb_bus = mbus;  assign if4.id_to_wb_ready = idr;

    logic        o_valid [3];
    logic        o_ready [3];
    logic        o_done  [3];
    logic        o_idle  [3];
    logic [37:0] o_idbus [3];
    logic [31:0] o_pc    [3];
    logic [63:0] o_inst  [3];
    logic [7:0]  o_count [3];

    assign o_valid[0] = if1.wb_to_id_valid;  assign o_valid[1] = if2.wb_to_id_valid;  assign o_valid[2] = if4.wb_to_id_valid;
    assign o_ready[0] = if1.wb_to_mem_ready; assign o_ready[1] = if2.wb_to_mem_ready; assign o_ready[2] = if4.wb_to_mem_ready;
    assign o_done[0]  = if1.wb_to_if_done;   assign o_done[1]  = if2.wb_to_if_done;   assign o_done[2]  = if4.wb_to_if_done;
    assign o_idle[0]  = if1.wb_idle;         assign o_idle[1]  = if2.wb_idle;         assign o_idle[2]  = if4.wb_idle;
    assign o_idbus[0] = if1.wb_to_id_bus;    assign o_idbus[1] = if2.wb_to_id_bus;    assign o_idbus[2] = if4.wb_to_id_bus;
    assign o_pc[0]    = if1.commit_pc;       assign o_pc[1]    = if2.commit_pc;       assign o_pc[2]    = if4.commit_pc;
    assign o_inst[0]  = if1.instret;         assign o_inst[1]  = if2.instret;         assign o_inst[2]  = 64'(if4.instret);
    assign o_count[0] = 8'(if1.wb_count);    assign o_count[1] = 8'(if2.wb_count);    assign o_count[2] = 8'(if4.wb_count);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference: every accepted entry is appended to a per-instance log; the
    // queue is simply the log slice [rd_n, wr_n). instret is a masked counter.
    logic [69:0] log_mem [3][4096];
    int          wr_n    [3];
    int          rd_n    [3];
    logic [63:0] m_inst  [3];

    function automatic int dep_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [63:0] cmask(input int k);
        return (k == 2) ? 64'hF : {64{1'b1}};
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [69:0] b, input logic ir);
        bit exp_pop  [3];
        bit exp_push [3];
        rst  = r;
        mv   = v;
        mbus = b;
        idr  = ir;
        #1;
        for (int k = 0; k < 3; k++) begin
            int          sz;
            logic [69:0] h;
            sz = wr_n[k] - rd_n[k];
            h  = log_mem[k][rd_n[k] % 4096];
            exp_pop[k]  = (sz != 0) && ir && !r;
            exp_push[k] = v && !r && ((sz < dep_of(k)) || exp_pop[k]);
            chk($sformatf("d%0d_valid", k), 128'(o_valid[k]), 128'(sz != 0));
            chk($sformatf("d%0d_ready", k), 128'(o_ready[k]), 128'((sz < dep_of(k)) || exp_pop[k]));
            chk($sformatf("d%0d_done",  k), 128'(o_done[k]),  128'(exp_pop[k]));
            chk($sformatf("d%0d_idle",  k), 128'(o_idle[k]),  128'(sz == 0));
            chk($sformatf("d%0d_count", k), 128'(o_count[k]), 128'(sz));
            chk($sformatf("d%0d_instret", k), 128'(o_inst[k]), 128'(m_inst[k]));
            if (sz != 0)
                chk($sformatf("d%0d_idbus", k), 128'(o_idbus[k]),
                    128'({h[37:1], h[0] && (h[5:1] != 5'd0)}));
            if (exp_pop[k])
                chk($sformatf("d%0d_commit_pc", k), 128'(o_pc[k]), 128'(h[69:38]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                rd_n[k]   = wr_n[k];
                m_inst[k] = '0;
            end else begin
                if (exp_pop[k]) begin
                    rd_n[k]++;
                    m_inst[k] = (m_inst[k] + 64'd1) & cmask(k);
                end
                if (exp_push[k]) begin
                    log_mem[k][wr_n[k] % 4096] = b;
                    wr_n[k]++;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [69:0] ent(input logic [31:0] pc, input logic [31:0] d,
                                        input logic [4:0] a, input logic w);
        return {pc, d, a, w};
    endfunction

    initial begin
        int thr;
        for (int k = 0; k < 3; k++) begin
            wr_n[k] = 0;
            rd_n[k] = 0;
            m_inst[k] = '0;
        end
        rst = 1'b1; mv = 1'b0; idr = 1'b0; mbus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then idle.
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("idle_after_reset", 128'(o_idle[1]), 128'(1));

        // Single entry: visible the cycle after push, retires with trace.
        cycle(1'b0, 1'b1, ent(32'h8000_0000, 32'h1234_5678, 5'd5, 1'b1), 1'b1);
        chk("tp1_idbus", 128'(o_idbus[1]), 128'({32'h1234_5678, 5'd5, 1'b1}));
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("tp1_instret", 128'(o_inst[1]), 128'(1));

        // x0 write: enable suppressed, still retires and counts.
        cycle(1'b0, 1'b1, ent(32'h8000_0004, 32'hDEAD_BEEF, 5'd0, 1'b1), 1'b1);
        chk("tp2_regw_eff", 128'(o_idbus[1][0]), 128'(0));
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("tp2_instret", 128'(o_inst[1]), 128'(2));

        // Fill DEPTH=2, third push stalls, then push+pop at full.
        cycle(1'b0, 1'b1, ent(32'h100, 32'h1, 5'd1, 1'b1), 1'b0);
        cycle(1'b0, 1'b1, ent(32'h104, 32'h2, 5'd2, 1'b1), 1'b0);
        chk("tp3_ready_full", 128'(o_ready[1]), 128'(0));
        chk("tp3_count_full", 128'(o_count[1]), 128'(2));
        cycle(1'b0, 1'b1, ent(32'h108, 32'h3, 5'd3, 1'b1), 1'b0);
        cycle(1'b0, 1'b1, ent(32'h108, 32'h3, 5'd3, 1'b1), 1'b1);
        repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);

        // Back-to-back stream of 10 through fresh queues; pointers wrap.
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'b1, ent(32'h2000 + 32'(i * 4), 32'($urandom), 5'(i + 1), 1'b1), 1'b1);
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("tp4_instret", 128'(o_inst[2]), 128'(10));
        chk("tp4_idle", 128'(o_idle[2]), 128'(1));

        // Reset with entries queued: no retire pulse, everything cleared.
        cycle(1'b0, 1'b1, ent(32'h300, 32'h7, 5'd7, 1'b1), 1'b0);
        cycle(1'b0, 1'b1, ent(32'h304, 32'h8, 5'd8, 1'b0), 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("tp5_valid", 128'(o_valid[1]), 128'(0));

        // Randomized traffic with shifting backpressure and occasional reset.
        thr = 50;
        for (int c = 0; c < 2000; c++) begin
            logic [4:0] a;
            if (c % 200 == 0) thr = $urandom_range(10, 90);
            a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) < 60),
                  ent($urandom, $urandom, a, 1'($urandom)),
                  ($urandom_range(0, 99) < thr));
        end
        repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
